// File: rtl/exmem_pkg.sv
// ----------------------------------------------------------------------------
// exmem_pkg
// Shared types and constants for the EX/MEM pipeline register (ex_mem_pipe).
//   ENTRY_DATA_WIDTH / ENTRY_RD_WIDTH : field widths of one stored entry
//   DEPTH / PTR_WIDTH                 : skid-buffer depth and pointer width
//   CTRL_*                            : bit positions inside the 3-bit Ctrl
//   exmem_entry_t                     : one buffered EX->MEM entry
//   exmem_state_e                     : occupancy state of the buffer
//   exmem_make_entry()                : builds an entry, squashing x0 writes
// ----------------------------------------------------------------------------
package exmem_pkg;

    localparam int ENTRY_DATA_WIDTH = 32;
    localparam int ENTRY_RD_WIDTH   = 5;

    localparam int DEPTH     = 2;
    localparam int PTR_WIDTH = 1;

    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    typedef struct packed {
        logic [ENTRY_DATA_WIDTH-1:0] result;
        logic [ENTRY_RD_WIDTH-1:0]   rd;
        logic [ENTRY_DATA_WIDTH-1:0] store;
        logic [2:0]                  ctrl;
    } exmem_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } exmem_state_e;

    // Register x0 is hard-wired to zero, so a write to it is dropped here
    // once, rather than having every later stage re-check the index.
    function automatic exmem_entry_t exmem_make_entry(
        input logic [ENTRY_DATA_WIDTH-1:0] result,
        input logic [ENTRY_RD_WIDTH-1:0]   rd,
        input logic [ENTRY_DATA_WIDTH-1:0] store,
        input logic [2:0]                  ctrl
    );
        exmem_entry_t e;
        e.result = result;
        e.rd     = rd;
        e.store  = store;
        e.ctrl   = ctrl;
        if (rd == '0) begin
            e.ctrl[CTRL_REGWRITE] = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_if
// Bundles the execute-side push port, the memory-side pop port and the
// flush control of the EX/MEM skid buffer.
//   in_valid/in_ready, ALUResult, RdAddr, StoreData, Ctrl : push side
//   out_valid/out_ready, out_result/rd/store/ctrl          : pop side (head)
//   flush                                                  : drop everything
//   fwd_valid/fwd_rd/fwd_data : hazard-unit forwarding, only when the
//                               EXMEM_FWD_EN macro is defined
// Modports: master = execute/memory environment, slave = the buffer.
// ----------------------------------------------------------------------------
interface ex_mem_pipe_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     ALUResult;
    logic [REG_ADDR_WIDTH-1:0] RdAddr;
    logic [DATA_WIDTH-1:0]     StoreData;
    logic [2:0]                Ctrl;
    logic                      flush;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [DATA_WIDTH-1:0]     out_store;
    logic [2:0]                out_ctrl;

`ifdef EXMEM_FWD_EN
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_rd;
    logic [DATA_WIDTH-1:0]     fwd_data;
`endif

    modport master (
        output in_valid, ALUResult, RdAddr, StoreData, Ctrl, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_store, out_ctrl
`ifdef EXMEM_FWD_EN
        , input fwd_valid, fwd_rd, fwd_data
`endif
    );

    modport slave (
        input  in_valid, ALUResult, RdAddr, StoreData, Ctrl, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_store, out_ctrl
`ifdef EXMEM_FWD_EN
        , output fwd_valid, fwd_rd, fwd_data
`endif
    );

endinterface

// File: rtl/ex_mem_pipe.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe
// EX/MEM pipeline register built as a 2-entry FIFO skid buffer, so the
// execute stage can keep issuing one entry per cycle while the memory stage
// applies backpressure.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; empties the buffer immediately
//   bus   : ex_mem_pipe_if.slave (push side, pop side, flush, optional fwd)
// Optional feature: define EXMEM_FWD_EN to drive fwd_valid/fwd_rd/fwd_data
// from the head entry for the hazard unit.
// ----------------------------------------------------------------------------
module ex_mem_pipe
    import exmem_pkg::*;
#(
    parameter int DATA_WIDTH     = ENTRY_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ENTRY_RD_WIDTH
) (
    input logic          clk,
    input logic          reset,
    ex_mem_pipe_if.slave bus
);

    exmem_state_e         state_q, state_d;
    exmem_entry_t         mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;

    logic         canAccept;
    logic         headValid;
    logic         doPush;
    logic         doPop;
    exmem_entry_t headEntry;
    exmem_entry_t newEntry;

    // Handshake qualifiers. Readiness and validity come from the state
    // register alone, so neither side sees a combinational path through us.
    always_comb begin
        canAccept = (state_q != FULL);
        headValid = (state_q != EMPTY);
        headEntry = mem_q[rd_ptr_q];
        doPush    = bus.in_valid && canAccept;
        doPop     = headValid && bus.out_ready;
        newEntry  = exmem_make_entry(ENTRY_DATA_WIDTH'(bus.ALUResult),
                                     ENTRY_RD_WIDTH'(bus.RdAddr),
                                     ENTRY_DATA_WIDTH'(bus.StoreData),
                                     bus.Ctrl);
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy. Flush wins over any same-cycle push or pop. When ONE
    // pushes and pops together the count is unchanged and the new entry
    // becomes the head, which falls out of the pointer update below.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (doPush) state_d = ONE;
                ONE: begin
                    if (doPush && !doPop) begin
                        state_d = FULL;
                    end else if (!doPush && doPop) begin
                        state_d = EMPTY;
                    end
                end
                FULL:    if (doPop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Read/write pointers; with a depth of two they wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (doPush) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            if (doPop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
    end

    // Pointer registers and entry storage. A flushed push is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (doPush && !bus.flush) begin
                mem_q[wr_ptr_q] <= newEntry;
            end
        end
    end

    // Head presentation; every data field is held at zero while no entry is
    // valid so stale contents never leak into the memory stage.
    always_comb begin
        bus.in_ready   = canAccept;
        bus.out_valid  = headValid;
        bus.out_result = '0;
        bus.out_rd     = '0;
        bus.out_store  = '0;
        bus.out_ctrl   = '0;
        if (headValid) begin
            bus.out_result = DATA_WIDTH'(headEntry.result);
            bus.out_rd     = REG_ADDR_WIDTH'(headEntry.rd);
            bus.out_store  = DATA_WIDTH'(headEntry.store);
            bus.out_ctrl   = headEntry.ctrl;
        end
    end

`ifdef EXMEM_FWD_EN
    // Forward only results already known in EX: loads are excluded because
    // their data only exists after the memory access.
    always_comb begin
        bus.fwd_valid = headValid && headEntry.ctrl[CTRL_REGWRITE]
                        && !headEntry.ctrl[CTRL_MEMREAD];
        bus.fwd_rd    = '0;
        bus.fwd_data  = '0;
        if (bus.fwd_valid) begin
            bus.fwd_rd   = REG_ADDR_WIDTH'(headEntry.rd);
            bus.fwd_data = DATA_WIDTH'(headEntry.result);
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_pipe
// Self-checking bench for ex_mem_pipe: directed scenarios with literal
// expectations, then randomized push/pop/flush traffic compared every cycle
// against a queue-based model of a 2-deep FIFO.
// Optional feature under test when EXMEM_FWD_EN is defined.
// ----------------------------------------------------------------------------
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [31:0] store;
        logic [2:0]  ctrl;
    } tbEntry_t;

    logic clk;
    logic reset;
    logic checkEn;
    int   checks;
    int   errors;

    tbEntry_t modelQ[$];

    ex_mem_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    ex_mem_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] result,
                                 input logic [4:0] rd, input logic [31:0] store,
                                 input logic [2:0] ctrl, input logic outReady,
                                 input logic flushIn);
        bus.in_valid  = valid;
        bus.ALUResult = result;
        bus.RdAddr    = rd;
        bus.StoreData = store;
        bus.Ctrl      = ctrl;
        bus.out_ready = outReady;
        bus.flush     = flushIn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two entries. On each edge a flush
    // empties it, otherwise the head leaves if the consumer is ready and the
    // offered entry joins if there was room at the start of the cycle.
    logic     mPop;
    logic     mPush;
    tbEntry_t mNew;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelQ.delete();
        end else if (bus.flush) begin
            modelQ.delete();
        end else begin
            mPop  = (modelQ.size() > 0) && bus.out_ready;
            mPush = bus.in_valid && (modelQ.size() < 2);
            mNew.result = bus.ALUResult;
            mNew.rd     = bus.RdAddr;
            mNew.store  = bus.StoreData;
            mNew.ctrl   = bus.Ctrl;
            if (bus.RdAddr == 5'd0) mNew.ctrl = bus.Ctrl & 3'b011;
            if (mPop)  void'(modelQ.pop_front());
            if (mPush) modelQ.push_back(mNew);
        end
    end

    // Every falling edge, all DUT outputs must match the model's view.
    tbEntry_t expHead;
    logic     expValid;
    always @(negedge clk) begin
        if (checkEn) begin
            expValid = (modelQ.size() > 0);
            expHead  = '0;
            if (expValid) expHead = modelQ[0];
            checkOutput("cyc_in_ready",  bus.in_ready,  modelQ.size() < 2);
            checkOutput("cyc_out_valid", bus.out_valid, expValid);
            checkOutput("cyc_out_result", bus.out_result, expHead.result);
            checkOutput("cyc_out_rd",    bus.out_rd,    expHead.rd);
            checkOutput("cyc_out_store", bus.out_store, expHead.store);
            checkOutput("cyc_out_ctrl",  bus.out_ctrl,  expHead.ctrl);
`ifdef EXMEM_FWD_EN
            begin
                logic fv;
                fv = expValid && expHead.ctrl[2] && !expHead.ctrl[1];
                checkOutput("cyc_fwd_valid", bus.fwd_valid, fv);
                checkOutput("cyc_fwd_rd",    bus.fwd_rd,    fv ? expHead.rd : 5'd0);
                checkOutput("cyc_fwd_data",  bus.fwd_data,  fv ? expHead.result : 32'd0);
            end
`endif
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        checks  = 0;
        errors  = 0;
        checkEn = 1'b0;
        reset   = 1'b1;
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 1'b0);
        tick();
        checkEn = 1'b1;
        checkOutput("rst_in_ready",   bus.in_ready,   1'b1);
        checkOutput("rst_out_valid",  bus.out_valid,  1'b0);
        checkOutput("rst_out_result", bus.out_result, 32'd0);
        reset = 1'b0;
        tick();

        // Single push, consumer ready.
        applyStimulus(1'b1, 32'h0000_0005, 5'd3, 32'd0, 3'b100, 1'b1, 1'b0);
        tick();
        checkOutput("single_valid",  bus.out_valid,  1'b1);
        checkOutput("single_result", bus.out_result, 32'd5);
        checkOutput("single_rd",     bus.out_rd,     5'd3);
        checkOutput("single_ctrl",   bus.out_ctrl,   3'b100);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("single_drained", bus.out_valid, 1'b0);

        // Backpressure fills the buffer, then drains in order.
        applyStimulus(1'b1, 32'h11, 5'd1, 32'hA, 3'b100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h22, 5'd2, 32'hB, 3'b001, 1'b0, 1'b0);
        tick();
        checkOutput("bp_full_ready", bus.in_ready,   1'b0);
        checkOutput("bp_head_a",     bus.out_result, 32'h11);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("bp_head_b",     bus.out_result, 32'h22);
        checkOutput("bp_store_b",    bus.out_store,  32'hB);
        checkOutput("bp_ready_back", bus.in_ready,   1'b1);
        tick();
        checkOutput("bp_empty", bus.out_valid, 1'b0);

        // Write to x0 loses RegWrite.
        applyStimulus(1'b1, 32'h77, 5'd0, 32'd0, 3'b100, 1'b0, 1'b0);
        tick();
        checkOutput("x0_valid", bus.out_valid, 1'b1);
        checkOutput("x0_ctrl",  bus.out_ctrl,  3'b000);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();

        // Streaming at one entry per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 5'd9, 32'd0, 3'b100, 1'b1, 1'b0);
            tick();
            checkOutput("stream_result", bus.out_result, 32'h100 + i);
            checkOutput("stream_ready",  bus.in_ready,   1'b1);
        end
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("stream_empty", bus.out_valid, 1'b0);

        // Flush while full, with a push offered.
        applyStimulus(1'b1, 32'hA1, 5'd4, 32'd0, 3'b100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hA2, 5'd5, 32'd0, 3'b100, 1'b0, 1'b0);
        tick();
        checkOutput("fl_full", bus.in_ready, 1'b0);
        applyStimulus(1'b1, 32'h99, 5'd6, 32'd0, 3'b100, 1'b0, 1'b1);
        tick();
        checkOutput("fl_valid",  bus.out_valid,  1'b0);
        checkOutput("fl_ready",  bus.in_ready,   1'b1);
        checkOutput("fl_result", bus.out_result, 32'd0);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 1'b0);
        tick();
        checkOutput("fl_no_ghost", bus.out_valid, 1'b0);

        // Flush with one entry held and a push offered.
        applyStimulus(1'b1, 32'hB1, 5'd4, 32'd0, 3'b100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hB2, 5'd5, 32'd0, 3'b100, 1'b1, 1'b1);
        tick();
        checkOutput("fl1_valid", bus.out_valid, 1'b0);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("fl1_no_ghost", bus.out_valid, 1'b0);

        // Asynchronous reset between edges while full.
        applyStimulus(1'b1, 32'hC1, 5'd7, 32'h5, 3'b100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hC2, 5'd8, 32'h6, 3'b100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_valid",  bus.out_valid,  1'b0);
        checkOutput("ar_ready",  bus.in_ready,   1'b1);
        checkOutput("ar_result", bus.out_result, 32'd0);
        checkOutput("ar_store",  bus.out_store,  32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("ar_no_stale", bus.out_valid, 1'b0);
        tick();
        checkOutput("ar_still_empty", bus.out_result, 32'd0);

`ifdef EXMEM_FWD_EN
        // Forwarding of an ALU result, then suppression for a load.
        applyStimulus(1'b1, 32'hDEAD, 5'd7, 32'd0, 3'b100, 1'b0, 1'b0);
        tick();
        checkOutput("fwd_valid", bus.fwd_valid, 1'b1);
        checkOutput("fwd_rd",    bus.fwd_rd,    5'd7);
        checkOutput("fwd_data",  bus.fwd_data,  32'hDEAD);
        applyStimulus(1'b1, 32'hBEEF, 5'd7, 32'd0, 3'b110, 1'b1, 1'b0);
        tick();
        checkOutput("fwd_load_valid", bus.fwd_valid,  1'b0);
        checkOutput("fwd_load_rd",    bus.fwd_rd,     5'd0);
        checkOutput("fwd_load_data",  bus.fwd_data,   32'd0);
        checkOutput("fwd_load_head",  bus.out_result, 32'hBEEF);
        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
`endif

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] rdR;
            rdR = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), $urandom, rdR, $urandom,
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0);
            if (n == 700) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        applyStimulus(1'b0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
